// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and register-index constants.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } fsm_e;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the source registers of the instruction in ID.
// Purely combinational and zero latency. It has no flow control.
module pipe_hazard_ctrl_hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic             id_ex_mem_read_i,
    input  logic [REG_W-1:0] id_ex_rt_i,
    input  logic [REG_W-1:0] if_id_rs_i,
    input  logic [REG_W-1:0] if_id_rt_i,
    output logic             load_use_o
);

    // A load that targets r0 never creates a dependency.
    assign load_use_o = id_ex_mem_read_i && (id_ex_rt_i != REG_ZERO) &&
                        ((id_ex_rt_i == if_id_rs_i) || (id_ex_rt_i == if_id_rt_i));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller: load-use stall, branch flush and MEM-stage wait sequencing with a timeout.
// Control outputs are combinational from the registered state. Memory backpressure comes through mem_ready and freezes the whole pipe.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ID_EX_MemRead,
    input  logic [REG_W-1:0] ID_EX_RegisterRt,
    input  logic [REG_W-1:0] IF_ID_RegisterRs,
    input  logic [REG_W-1:0] IF_ID_RegisterRt,
    input  logic             branch_taken,
    input  logic             EX_MEM_MemRead,
    input  logic             EX_MEM_MemWrite,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_Flush,
    output logic             ID_EX_Flush,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Hold,
    output logic             EX_Flush,
    output logic             MEM_WB_Flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WC_W = $clog2(TIMEOUT);

    fsm_e             fsm_q;
    logic [WC_W-1:0]  wait_cnt_q;
    logic             mem_err_q;
    logic [CNT_W-1:0] stall_q;

    logic load_use;
    logic mem_access;
    logic freeze;
    logic timeout_hit;

    pipe_hazard_ctrl_hazard_detect u_hazard_detect (
        .id_ex_mem_read_i (ID_EX_MemRead),
        .id_ex_rt_i       (ID_EX_RegisterRt),
        .if_id_rs_i       (IF_ID_RegisterRs),
        .if_id_rt_i       (IF_ID_RegisterRt),
        .load_use_o       (load_use)
    );

    assign mem_access  = EX_MEM_MemRead || EX_MEM_MemWrite;
    assign freeze      = ((fsm_q == RUN) && mem_access && !mem_ready) ||
                         ((fsm_q == MEM_WAIT) && !mem_ready) ||
                         (fsm_q == ERROR);
    assign timeout_hit = (fsm_q == MEM_WAIT) && !mem_ready && (wait_cnt_q == WC_W'(TIMEOUT - 1));

    always_comb begin
        mem_req      = 1'b0;
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        IF_Flush     = 1'b0;
        ID_EX_Flush  = 1'b0;
        ID_EX_Write  = 1'b0;
        EX_MEM_Hold  = 1'b0;
        EX_Flush     = 1'b0;
        MEM_WB_Flush = 1'b0;
        if (!reset) begin
            mem_req  = mem_access && (fsm_q != ERROR);
            EX_Flush = timeout_hit;
            // Freeze outranks load-use, which outranks a taken branch; losers re-evaluate later.
            if (freeze) begin
                EX_MEM_Hold  = 1'b1;
                MEM_WB_Flush = 1'b1;
            end else if (load_use) begin
                ID_EX_Flush = 1'b1;
                ID_EX_Write = 1'b1;
            end else begin
                PC_Write    = 1'b1;
                IF_ID_Write = 1'b1;
                ID_EX_Write = 1'b1;
                IF_Flush    = branch_taken;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q      <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            case (fsm_q)
                RUN: begin
                    if (mem_access && !mem_ready) begin
                        fsm_q      <= MEM_WAIT;
                        wait_cnt_q <= WC_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        fsm_q      <= RUN;
                        wait_cnt_q <= '0;
                    end else if (timeout_hit) begin
                        fsm_q     <= ERROR;
                        mem_err_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WC_W'(1);
                    end
                end
                default: begin
                    fsm_q <= ERROR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if ((freeze || load_use) && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_q;

endmodule
